// File: rtl/pipelined_mem_pkg.sv
// Shared types and helpers for pipelined_mem: data-port function codes,
// controller states and the access-size/alignment rules.
package pipelined_mem_pkg;

    // Data-port function codes carried on d_fn
    typedef enum logic [2:0] {
        MEM_LB  = 3'd0,
        MEM_LH  = 3'd1,
        MEM_LW  = 3'd2,
        MEM_LBU = 3'd3,
        MEM_LHU = 3'd4,
        MEM_SB  = 3'd5,
        MEM_SH  = 3'd6,
        MEM_SW  = 3'd7
    } mem_fn_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

    function automatic logic fn_is_store(input logic [2:0] fn);
        return (fn == MEM_SB) || (fn == MEM_SH) || (fn == MEM_SW);
    endfunction

    // Words need offset 0, halves need an even offset, bytes never fault
    function automatic logic fn_misaligned(input logic [2:0] fn, input logic [1:0] off);
        logic w_mis;
        case (fn)
            MEM_LW, MEM_SW:          w_mis = (off != 2'b00);
            MEM_LH, MEM_LHU, MEM_SH: w_mis = off[0];
            default:                 w_mis = 1'b0;
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/pipelined_mem_if.sv
// Request/response bundle for the fetch (i_*) and data (d_*) ports.
// master = CPU side, slave = memory side.
interface pipelined_mem_if;

    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_inst;
    logic        i_rsp_err;

    logic        d_req_valid;
    logic        d_req_ready;
    logic [2:0]  d_fn;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic        d_rsp_err;

    modport master (
        output i_req_valid, i_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_inst, i_rsp_err,
        output d_req_valid, d_fn, d_addr, d_wdata,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
    );

    modport slave (
        input  i_req_valid, i_addr,
        output i_req_ready, i_rsp_valid, i_rsp_inst, i_rsp_err,
        input  d_req_valid, d_fn, d_addr, d_wdata,
        output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
    );

endinterface

// File: rtl/mem_lat_pipe.sv
// Response delay line: valid/err/data shifted through DEPTH registered
// stages (DEPTH >= 1). Reset empties every stage.
module mem_lat_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic         i_err,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic         o_err,
    output logic [W-1:0] o_data
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_err;
    logic [W-1:0]     r_data [DEPTH];

    // Shift one stage per clock; stage 0 takes the incoming beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_err   <= '0;
            for (int unsigned s = 0; s < DEPTH; s++) begin
                r_data[s] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_err[0]   <= i_err;
            r_data[0]  <= i_data;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_err[s]   <= r_err[s-1];
                r_data[s]  <= r_data[s-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_err   = r_err[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/pipelined_mem.sv
// Dual-port RV32 memory: instruction fetch port plus a byte/half/word
// load-store data port, fixed READ_LAT response latency, optional
// post-reset zero-fill.
module pipelined_mem
    import pipelined_mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned READ_LAT       = 1,   // 1..4
    parameter int unsigned CLEAR_ON_RESET = 0,
    parameter string       INIT_FILE      = ""
) (
    input  logic           clk,
    input  logic           reset,
    pipelined_mem_if.slave bus
);

    localparam int unsigned WIDX  = ADDR_W - 2;
    localparam int unsigned WORDS = 1 << WIDX;
    // A named INIT_FILE image is preloaded into r_mem by the environment
    // that supplies it; the zero-fill is skipped so that image survives.
    localparam bit DO_CLEAR = (CLEAR_ON_RESET != 0) && (INIT_FILE == "");

    typedef logic [WIDX-1:0] widx_t;

    logic [31:0] r_mem [0:WORDS-1];

    mem_state_e r_state, w_state_nxt;
    widx_t      r_clr_idx, w_clr_idx_nxt;
    logic       w_ready;
    logic       w_clr_we;

    logic        w_i_acc, w_d_acc;
    widx_t       w_i_idx, w_d_idx;
    logic [1:0]  w_d_off;
    logic [31:0] w_d_word;
    logic        w_d_mis, w_d_store;
    logic [15:0] w_d_half;
    logic [7:0]  w_d_byte;
    logic [31:0] w_d_load;
    logic [3:0]  w_be;
    logic [31:0] w_wdat;

    logic        r_i_v, r_i_err, r_d_v, r_d_err;
    logic [31:0] r_i_data, r_d_data;

    // Controller state and zero-fill word counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if (DO_CLEAR) r_state <= ST_CLEAR;
            else          r_state <= ST_READY;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // Next state: walk every word once in CLEAR, then accept requests forever
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_ready       = 1'b0;
        w_clr_we      = 1'b0;
        unique case (r_state)
            ST_CLEAR: begin
                w_clr_we      = 1'b1;
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (r_clr_idx == '1) w_state_nxt = ST_READY;
            end
            ST_READY: w_ready = 1'b1;
            default:  w_state_nxt = ST_READY;
        endcase
    end

    assign bus.i_req_ready = w_ready;
    assign bus.d_req_ready = w_ready;

    assign w_i_acc   = bus.i_req_valid && w_ready;
    assign w_d_acc   = bus.d_req_valid && w_ready;
    assign w_i_idx   = bus.i_addr[ADDR_W-1:2];
    assign w_d_idx   = bus.d_addr[ADDR_W-1:2];
    assign w_d_off   = bus.d_addr[1:0];
    assign w_d_word  = r_mem[w_d_idx];
    assign w_d_mis   = fn_misaligned(bus.d_fn, w_d_off);
    assign w_d_store = fn_is_store(bus.d_fn);

    // Load lane selection and extension; stores and faults return zero
    always_comb begin
        w_d_half = w_d_off[1] ? w_d_word[31:16] : w_d_word[15:0];
        case (w_d_off)
            2'd0:    w_d_byte = w_d_word[7:0];
            2'd1:    w_d_byte = w_d_word[15:8];
            2'd2:    w_d_byte = w_d_word[23:16];
            default: w_d_byte = w_d_word[31:24];
        endcase
        case (bus.d_fn)
            MEM_LW:  w_d_load = w_d_word;
            MEM_LH:  w_d_load = {{16{w_d_half[15]}}, w_d_half};
            MEM_LHU: w_d_load = {16'h0000, w_d_half};
            MEM_LBU: w_d_load = {24'h000000, w_d_byte};
            default: w_d_load = {{24{w_d_byte[7]}}, w_d_byte};
        endcase
        if (w_d_store || w_d_mis) w_d_load = '0;
    end

    // Store byte-lane enables with data replicated across lanes
    always_comb begin
        w_be   = '0;
        w_wdat = '0;
        case (bus.d_fn)
            MEM_SB: begin
                w_be   = 4'b0001 << w_d_off;
                w_wdat = {4{bus.d_wdata[7:0]}};
            end
            MEM_SH: begin
                w_be   = w_d_off[1] ? 4'b1100 : 4'b0011;
                w_wdat = {2{bus.d_wdata[15:0]}};
            end
            MEM_SW: begin
                w_be   = 4'b1111;
                w_wdat = bus.d_wdata;
            end
            default: ;
        endcase
        if (!w_d_acc || w_d_mis) w_be = '0;
    end

    // Storage: zero-fill writes in CLEAR, lane writes on accepted stores
    always_ff @(posedge clk) begin
        if (!reset && w_clr_we) begin
            r_mem[r_clr_idx] <= '0;
        end else begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_d_idx][8*b +: 8] <= w_wdat[8*b +: 8];
            end
        end
    end

    // First response stage: read data captured at the acceptance edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i_v    <= 1'b0;
            r_i_err  <= 1'b0;
            r_i_data <= '0;
            r_d_v    <= 1'b0;
            r_d_err  <= 1'b0;
            r_d_data <= '0;
        end else begin
            r_i_v    <= w_i_acc;
            r_i_err  <= w_i_acc && (bus.i_addr[1:0] != 2'b00);
            r_i_data <= w_i_acc ? r_mem[w_i_idx] : '0;
            r_d_v    <= w_d_acc;
            r_d_err  <= w_d_acc && w_d_mis;
            r_d_data <= w_d_acc ? w_d_load : '0;
        end
    end

    if (READ_LAT > 1) begin : g_lat
        mem_lat_pipe #(.DEPTH(READ_LAT - 1), .W(32)) u_i_pipe (
            .clk     (clk),
            .rst     (reset),
            .i_valid (r_i_v),
            .i_err   (r_i_err),
            .i_data  (r_i_data),
            .o_valid (bus.i_rsp_valid),
            .o_err   (bus.i_rsp_err),
            .o_data  (bus.i_rsp_inst)
        );
        mem_lat_pipe #(.DEPTH(READ_LAT - 1), .W(32)) u_d_pipe (
            .clk     (clk),
            .rst     (reset),
            .i_valid (r_d_v),
            .i_err   (r_d_err),
            .i_data  (r_d_data),
            .o_valid (bus.d_rsp_valid),
            .o_err   (bus.d_rsp_err),
            .o_data  (bus.d_rsp_rdata)
        );
    end else begin : g_nolat
        assign bus.i_rsp_valid = r_i_v;
        assign bus.i_rsp_err   = r_i_err;
        assign bus.i_rsp_inst  = r_i_data;
        assign bus.d_rsp_valid = r_d_v;
        assign bus.d_rsp_err   = r_d_err;
        assign bus.d_rsp_rdata = r_d_data;
    end

endmodule

// File: tb/tb_pipelined_mem.sv
// Bench for pipelined_mem: three instances cover zero-fill timing,
// the load/store/latency rules against a byte-array model, and reset
// while responses are in flight.
module tb_pipelined_mem;
    import pipelined_mem_pkg::*;

    localparam int unsigned LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;

    pipelined_mem_if bus0 ();
    pipelined_mem_if bus1 ();
    pipelined_mem_if bus2 ();

    pipelined_mem #(.ADDR_W(6), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .reset(rst0), .bus(bus0.slave));
    pipelined_mem #(.ADDR_W(8), .READ_LAT(LAT1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .reset(rst1), .bus(bus1.slave));
    pipelined_mem #(.ADDR_W(8), .READ_LAT(2), .CLEAR_ON_RESET(0)) u_dut2 (
        .clk(clk), .reset(rst2), .bus(bus2.slave));

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%010h expected 0x%010h", name, act, exp);
    endtask

    // ---------------- reference model for dut1 (byte-addressed) ----------
    logic [7:0] mb [256];

    function automatic void model_i(input logic [31:0] addr, output logic [31:0] inst, output logic err);
        int unsigned a;
        a = (addr % 256) & ~32'd3;
        inst = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
        err = (addr % 4) != 0;
    endfunction

    function automatic void model_d(input logic [2:0] fn, input logic [31:0] addr, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic err);
        int unsigned a, sz;
        bit sgn, st;
        logic [31:0] val;
        a = addr % 256;
        st = 1'b0;
        sgn = 1'b0;
        case (fn)
            MEM_LW:  sz = 4;
            MEM_LH:  begin sz = 2; sgn = 1'b1; end
            MEM_LHU: sz = 2;
            MEM_LBU: sz = 1;
            MEM_SB:  begin sz = 1; st = 1'b1; end
            MEM_SH:  begin sz = 2; st = 1'b1; end
            MEM_SW:  begin sz = 4; st = 1'b1; end
            default: begin sz = 1; sgn = 1'b1; end
        endcase
        err = (a % sz) != 0;
        rd = 32'h0;
        if (err) return;
        if (st) begin
            for (int unsigned k = 0; k < sz; k++) mb[a+k] = wd[8*k +: 8];
        end else begin
            val = 32'h0;
            for (int unsigned k = 0; k < sz; k++) val = val | (32'(mb[a+k]) << (8*k));
            if (sgn && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8*sz));
            rd = val;
        end
    endfunction

    typedef struct packed { logic v; logic err; logic [31:0] data; } rsp_t;
    rsp_t exp_i [8];
    rsp_t exp_d [8];
    int unsigned cyc;

    // One dut1 cycle: drive, schedule expected response LAT1 cycles on,
    // compare this cycle's expected response at the negedge.
    task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ei, input logic eie,
                        input logic dv, input logic [2:0] fn, input logic [31:0] da, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ede, input string tag);
        int unsigned s;
        bus1.i_req_valid = iv;
        bus1.i_addr      = ia;
        bus1.d_req_valid = dv;
        bus1.d_fn        = fn;
        bus1.d_addr      = da;
        bus1.d_wdata     = wd;
        s = (cyc + LAT1) % 8;
        exp_i[s] = '{v: iv, err: eie, data: ei};
        exp_d[s] = '{v: dv, err: ede, data: ed};
        @(negedge clk);
        s = cyc % 8;
        check($sformatf("%s/i c%0d", tag, cyc),
              {3'b0, bus1.i_req_ready, bus1.i_rsp_valid,
               exp_i[s].v ? {bus1.i_rsp_err, bus1.i_rsp_inst} : 33'd0},
              {3'b0, 1'b1, exp_i[s].v, exp_i[s].v ? {exp_i[s].err, exp_i[s].data} : 33'd0});
        check($sformatf("%s/d c%0d", tag, cyc),
              {3'b0, bus1.d_req_ready, bus1.d_rsp_valid,
               exp_d[s].v ? {bus1.d_rsp_err, bus1.d_rsp_rdata} : 33'd0},
              {3'b0, 1'b1, exp_d[s].v, exp_d[s].v ? {exp_d[s].err, exp_d[s].data} : 33'd0});
        exp_i[s] = '0;
        exp_d[s] = '0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic iv; logic [31:0] ia; logic [31:0] ei; logic eie;
        logic dv; logic [2:0] fn; logic [31:0] da; logic [31:0] wd; logic [31:0] ed; logic ede;
    } vec_t;
    vec_t tbl [17];

    // ---------------- dut0 helpers ----------------
    task automatic measure_clear0(output int unsigned n);
        n = 0;
        @(negedge clk);
        while (bus0.d_req_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic acc0(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input string tag);
        @(posedge clk);
        #1;
        bus0.d_req_valid = 1'b1;
        bus0.d_fn        = fn;
        bus0.d_addr      = a;
        bus0.d_wdata     = wd;
        @(posedge clk);
        #1;
        bus0.d_req_valid = 1'b0;
        @(negedge clk);
        check(tag, {6'b0, bus0.d_rsp_valid, bus0.d_rsp_err, bus0.d_rsp_rdata}, {6'b0, 1'b1, 1'b0, erd});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        logic [31:0] di, dd;
        logic die, dde;
        logic iv, dv, eie, ede;
        logic [31:0] ia, da, wd, ei, ed;
        logic [2:0] fn;

        {bus0.i_req_valid, bus0.i_addr, bus0.d_req_valid, bus0.d_fn, bus0.d_addr, bus0.d_wdata} = '0;
        {bus1.i_req_valid, bus1.i_addr, bus1.d_req_valid, bus1.d_fn, bus1.d_addr, bus1.d_wdata} = '0;
        {bus2.i_req_valid, bus2.i_addr, bus2.d_req_valid, bus2.d_fn, bus2.d_addr, bus2.d_wdata} = '0;
        for (int i = 0; i < 256; i++) mb[i] = 8'h00;
        for (int i = 0; i < 8; i++) begin exp_i[i] = '0; exp_d[i] = '0; end

        repeat (2) @(posedge clk);
        #1;
        check("rst_d_valid0", {39'b0, bus1.d_rsp_valid}, 40'd0);
        check("rst_i_valid0", {39'b0, bus0.i_rsp_valid}, 40'd0);

        // ---- dut0: zero-fill length, restart mid-fill, content cleared ----
        rst0 = 1'b0;
        measure_clear0(n);
        check("clr0_len", 40'(n), 40'd16);
        check("clr0_irdy", {39'b0, bus0.i_req_ready}, 40'd1);
        acc0(MEM_SW, 32'h3C, 32'hFFFF_FFFF, 32'h0, "clr0_sw");
        acc0(MEM_LW, 32'h3C, 32'h0, 32'hFFFF_FFFF, "clr0_lw_pre");
        @(posedge clk);
        #1;
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        measure_clear0(n);
        check("clr0_restart_len", 40'(n), 40'd16);
        acc0(MEM_LW, 32'h3C, 32'h0, 32'h0, "clr0_lw_zero");

        // ---- dut1: table then random against model ----
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus1.d_req_ready !== 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("clr1_len", 40'(n), 40'd64);
        @(posedge clk);
        #1;
        cyc = 0;

        tbl[0]  = '{1'b0, 32'h0,   32'h0,         1'b0, 1'b1, MEM_SW,  32'h10,        32'hDEADBEEF, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 32'h0,   32'h0,         1'b0, 1'b1, MEM_LW,  32'h10,        32'h0,        32'hDEADBEEF,  1'b0};
        tbl[2]  = '{1'b0, 32'h0,   32'h0,         1'b0, 1'b1, MEM_LH,  32'h12,        32'h0,        32'hFFFFDEAD,  1'b0};
        tbl[3]  = '{1'b0, 32'h0,   32'h0,         1'b0, 1'b1, MEM_LHU, 32'h12,        32'h0,        32'h0000DEAD,  1'b0};
        tbl[4]  = '{1'b0, 32'h0,   32'h0,         1'b0, 1'b1, MEM_LB,  32'h13,        32'h0,        32'hFFFFFFDE,  1'b0};
        tbl[5]  = '{1'b0, 32'h0,   32'h0,         1'b0, 1'b1, MEM_LBU, 32'h13,        32'h0,        32'h000000DE,  1'b0};
        tbl[6]  = '{1'b0, 32'h0,   32'h0,         1'b0, 1'b1, MEM_SW,  32'h20,        32'h11223344, 32'h0,         1'b0};
        tbl[7]  = '{1'b0, 32'h0,   32'h0,         1'b0, 1'b1, MEM_SB,  32'h21,        32'hFFFFFF7F, 32'h0,         1'b0};
        tbl[8]  = '{1'b1, 32'h02,  32'h0,         1'b1, 1'b1, MEM_LW,  32'h20,        32'h0,        32'h11227F44,  1'b0};
        tbl[9]  = '{1'b1, 32'h12,  32'hDEADBEEF,  1'b1, 1'b1, MEM_SW,  32'h22,        32'hAAAAAAAA, 32'h0,         1'b1};
        tbl[10] = '{1'b0, 32'h0,   32'h0,         1'b0, 1'b1, MEM_LW,  32'h20,        32'h0,        32'h11227F44,  1'b0};
        tbl[11] = '{1'b0, 32'h0,   32'h0,         1'b0, 1'b1, MEM_LH,  32'h23,        32'h0,        32'h0,         1'b1};
        tbl[12] = '{1'b1, 32'h40,  32'h0,         1'b0, 1'b1, MEM_SW,  32'h40,        32'h12345678, 32'h0,         1'b0};
        tbl[13] = '{1'b1, 32'h40,  32'h12345678,  1'b0, 1'b0, MEM_LB,  32'h0,         32'h0,        32'h0,         1'b0};
        tbl[14] = '{1'b0, 32'h0,   32'h0,         1'b0, 1'b1, MEM_SH,  32'h42,        32'hBEEF5A5A, 32'h0,         1'b0};
        tbl[15] = '{1'b1, 32'h140, 32'h5A5A5678,  1'b0, 1'b1, MEM_LW,  32'h40,        32'h0,        32'h5A5A5678,  1'b0};
        tbl[16] = '{1'b0, 32'h0,   32'h0,         1'b0, 1'b1, MEM_LB,  32'hFFFF0010,  32'h0,        32'hFFFFFFEF,  1'b0};

        for (int k = 0; k < 17; k++) begin
            if (tbl[k].iv) model_i(tbl[k].ia, di, die);
            if (tbl[k].dv) model_d(tbl[k].fn, tbl[k].da, tbl[k].wd, dd, dde);
            step(tbl[k].iv, tbl[k].ia, tbl[k].ei, tbl[k].eie,
                 tbl[k].dv, tbl[k].fn, tbl[k].da, tbl[k].wd, tbl[k].ed, tbl[k].ede,
                 $sformatf("vec%0d", k));
        end

        for (int k = 0; k < 400; k++) begin
            iv = 1'($urandom_range(0, 1));
            ia = $urandom & 32'hFFFF_FF3F;
            dv = 1'($urandom_range(0, 3) != 0);
            fn = 3'($urandom_range(0, 7));
            da = $urandom & 32'hFFFF_FF3F;
            wd = $urandom;
            ei = 32'h0; eie = 1'b0; ed = 32'h0; ede = 1'b0;
            if (iv) model_i(ia, ei, eie);
            if (dv) model_d(fn, da, wd, ed, ede);
            step(iv, ia, ei, eie, dv, fn, da, wd, ed, ede, "rnd");
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, "drain");
        end

        // ---- dut2: reset with two responses in flight ----
        rst2 = 1'b0;
        bus2.d_req_valid = 1'b1;
        bus2.d_fn        = MEM_SW;
        bus2.d_addr      = 32'h08;
        bus2.d_wdata     = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus2.d_fn        = MEM_LW;
        bus2.i_req_valid = 1'b1;
        bus2.i_addr      = 32'h08;
        @(posedge clk);
        #1;
        bus2.i_addr      = 32'h0C;
        @(posedge clk);
        #1;
        bus2.d_req_valid = 1'b0;
        bus2.i_req_valid = 1'b0;
        check("rst2_pre_d", {6'b0, bus2.d_rsp_valid, bus2.d_rsp_err, bus2.d_rsp_rdata},
              {6'b0, 1'b1, 1'b0, 32'hCAFEF00D});
        check("rst2_pre_i", {6'b0, bus2.i_rsp_valid, bus2.i_rsp_err, bus2.i_rsp_inst},
              {6'b0, 1'b1, 1'b0, 32'hCAFEF00D});
        rst2 = 1'b1;
        #1;
        check("rst2_drop", {38'b0, bus2.i_rsp_valid, bus2.d_rsp_valid}, 40'd0);
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rst2_stale%0d", k), {38'b0, bus2.i_rsp_valid, bus2.d_rsp_valid}, 40'd0);
        end
        @(posedge clk);
        #1;
        bus2.d_req_valid = 1'b1;
        bus2.d_fn        = MEM_LW;
        bus2.d_addr      = 32'h08;
        bus2.i_req_valid = 1'b1;
        bus2.i_addr      = 32'h08;
        @(posedge clk);
        #1;
        bus2.d_req_valid = 1'b0;
        bus2.i_req_valid = 1'b0;
        @(negedge clk);
        check("rst2_lat_early", {38'b0, bus2.i_rsp_valid, bus2.d_rsp_valid}, 40'd0);
        @(negedge clk);
        check("rst2_keep_d", {6'b0, bus2.d_rsp_valid, bus2.d_rsp_err, bus2.d_rsp_rdata},
              {6'b0, 1'b1, 1'b0, 32'hCAFEF00D});
        check("rst2_keep_i", {6'b0, bus2.i_rsp_valid, bus2.i_rsp_err, bus2.i_rsp_inst},
              {6'b0, 1'b1, 1'b0, 32'hCAFEF00D});
        @(negedge clk);
        check("rst2_one_beat", {38'b0, bus2.i_rsp_valid, bus2.d_rsp_valid}, 40'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipelined_mem.md
Name: pipelined_mem

Overview:
Synthesizable successor to the testbench byte memory: dual-port (instruction fetch + data) RV32 memory with a parametrised read latency and a valid/ready request handshake.
- Loads and stores are encoded by the `MEM_*` function codes and are naturally aligned; misaligned accesses are flagged as errors.
- Optional post-reset zero-fill sequence.
- Sits between the CPU pipeline (IF port, EX/MEM port) and is also instantiated by the emulator bench.

Parameters:
ADDR_W, 16, byte-address bits actually decoded; upper address bits ignored (wrap modulo 2**ADDR_W).
READ_LAT, 1, cycles from request acceptance to response valid; legal 1..4.
CLEAR_ON_RESET, 0, 1 = zero-fill all words after reset deassert.
INIT_FILE, "", hex image loaded at elaboration if non-empty (byte-per-line format, little-endian).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
i_req_valid  in  1  fetch request
i_req_ready  out  1  fetch request accepted when valid&&ready
i_addr  in  32  fetch byte address
i_rsp_valid  out  1  fetch response valid
i_rsp_inst  out  32  fetched word
i_rsp_err  out  1  fetch misaligned (i_addr[1:0]!=0)
d_req_valid  in  1  data request
d_req_ready  out  1  data request accepted when valid&&ready
d_fn  in  3  `MEM_LB/LH/LW/LBU/LHU/SB/SH/SW` (define.vh)
d_addr  in  32  data byte address
d_wdata  in  32  store data (low bytes used for SB/SH)
d_rsp_valid  out  1  data response valid (loads and stores)
d_rsp_rdata  out  32  extended load result; 0 for stores and errors
d_rsp_err  out  1  misaligned access

Behaviour:
- Storage: 2**(ADDR_W-2) words × 32 bits with byte-lane write enables; word index = addr[ADDR_W-1:2].
- Reset (async) sets both response valid/err/data outputs to 0, clears the latency pipelines, and forces state to CLEAR (if CLEAR_ON_RESET) else READY. Memory contents are never altered by reset itself.
- FSM states: CLEAR, READY.
  - CLEAR: a counter walks word 0..last, writing 0 once per cycle; both req_ready are 0.
  - After writing the last word, go to READY next cycle.
  - Reset asserted mid-CLEAR restarts the walk at word 0.
  - READY: both req_ready = 1 every cycle (no backpressure).
- Requests are accepted on the rising edge with valid&&ready. Response is valid exactly READ_LAT cycles later for exactly one cycle. Back-to-back requests give back-to-back responses, in order, per port.
- Loads:
  - LW: the word.
  - LH/LHU: half selected by addr[1], sign/zero-extended.
  - LB/LBU: byte selected by addr[1:0], sign/zero-extended.
- Stores: the write commits at the acceptance edge, and only the addressed byte lanes change.
- Alignment:
  - LW/SW require addr[1:0]==0.
  - LH/LHU/SH require addr[0]==0.
  - Bytes are always aligned.
  - A misaligned access suppresses the write, returns rdata=0, and sets err=1 in its response beat.
- Read data is sampled at the acceptance edge (read-before-write).
  - A load and a store to the same word on the same edge (I-port vs D-port) returns the old data.
  - A D-port load in the cycle after a store to the same word returns the new data.
- The I-port never writes; i_rsp_inst returns the full word even when err=1 (word index ignores addr[1:0]).
- Unknown d_fn codes behave as LB (matching the legacy default).
- Output data is registered; there are no combinational paths from request inputs to outputs.

Decomposition:
- define.vh keeps the `MEM_*` function codes; add `MEM_NONE` only if the CPU needs an idle code (an idle request is simply d_req_valid=0).
- Sub-module mem_lat_pipe: a parametrised valid/data/err shift register of depth READ_LAT-1, instantiated once per port after the first registered stage.
- Load extension and alignment check remain inline, combinational before the first stage.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_W=6 → req_ready low for 16 cycles after reset falls, then high; LW addr 0x3C returns 0x00000000.
- READ_LAT=3: SW 0xDEADBEEF @0x10, then LW/LH/LHU/LB/LBU @0x10/0x12/0x12/0x13/0x13 back-to-back → responses at +3 cycles each, consecutive: 0xDEADBEEF, 0xFFFFDEAD, 0x0000DEAD, 0xFFFFFFDE, 0x000000DE.
- SB 0x7F @0x21 over word 0x11223344 @0x20 → later LW @0x20 = 0x11227F44.
- Misaligned: SW @0x22 data 0xAAAAAAAA → d_rsp_err=1, rdata=0; subsequent LW @0x20 unchanged. LH @0x23 → err=1. I-fetch @0x02 → i_rsp_err=1.
- Same-edge I-fetch @0x40 with D SW 0x12345678 @0x40 (old 0) → i_rsp_inst=0; next fetch @0x40 = 0x12345678.
- Reset pulsed mid-stream with 2 responses in flight (READ_LAT=2) → both rsp_valid drop immediately and no stale response appears after reset releases; memory keeps its pre-reset stores.
